// File: rtl/key_debounce.sv
// key_debounce -- pushbutton conditioner.
//
// Synchronizes a raw, bouncing, active-low pushbutton into the I_clk domain,
// debounces both edges over T_DEBOUNCE cycles and classifies each press as
// short or long (held for T_LONG cycles).
//
// Ports:
//   I_clk            system clock, rising edge
//   I_reset_n        asynchronous active-low reset
//   I_key_n          raw pushbutton, 0 = pressed, asynchronous, may bounce
//   O_key_level      debounced key state, 1 = pressed
//   O_press_pulse    one-cycle pulse on debounced press
//   O_release_pulse  one-cycle pulse on debounced release
//   O_short_press    one-cycle pulse on release of a press shorter than T_LONG
//   O_long_press     one-cycle pulse when the hold time reaches T_LONG
module key_debounce #(
  parameter int unsigned T_DEBOUNCE = 500000,
  parameter int unsigned T_LONG     = 25000000
) (
  input  logic I_clk,
  input  logic I_reset_n,
  input  logic I_key_n,
  output logic O_key_level,
  output logic O_press_pulse,
  output logic O_release_pulse,
  output logic O_short_press,
  output logic O_long_press
);

  localparam logic [25:0] LP_DB_END   = 26'(T_DEBOUNCE - 1);
  localparam logic [25:0] LP_HOLD_END = 26'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS_DB = 3'd1,
    S_PRESSED  = 3'd2,
    S_LONG     = 3'd3,
    S_REL_DB   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [25:0] r_cnt;
  logic [25:0] w_cnt_nxt;
  logic [25:0] r_hold;
  logic [25:0] w_hold_nxt;
  logic        r_long_flag;
  logic        w_long_flag_nxt;

  logic        r_sync1;
  logic        r_sync2;
  logic        w_key_s;

  logic        w_level_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_short_nxt;
  logic        w_long_nxt;

  // Two-flop synchronizer; idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= I_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_s = ~r_sync2;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_hold          <= '0;
      r_long_flag     <= 1'b0;
      O_key_level     <= 1'b0;
      O_press_pulse   <= 1'b0;
      O_release_pulse <= 1'b0;
      O_short_press   <= 1'b0;
      O_long_press    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_hold          <= w_hold_nxt;
      r_long_flag     <= w_long_flag_nxt;
      O_key_level     <= w_level_nxt;
      O_press_pulse   <= w_press_nxt;
      O_release_pulse <= w_release_nxt;
      O_short_press   <= w_short_nxt;
      O_long_press    <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_long_flag_nxt = r_long_flag;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_short_nxt     = 1'b0;
    w_long_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_state_nxt = S_PRESS_DB;
          w_cnt_nxt   = '0;
        end
      end

      S_PRESS_DB: begin
        if (!w_key_s) begin
          w_state_nxt     = S_IDLE;
          w_long_flag_nxt = 1'b0;
        end else if (r_cnt == LP_DB_END) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end

      // Release is tested first so it wins over a coincident long-press.
      S_PRESSED: begin
        if (!w_key_s) begin
          w_state_nxt = S_REL_DB;
          w_cnt_nxt   = '0;
        end else if (r_hold == LP_HOLD_END) begin
          w_state_nxt     = S_LONG;
          w_long_flag_nxt = 1'b1;
          w_long_nxt      = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 26'd1;
        end
      end

      S_LONG: begin
        if (!w_key_s) begin
          w_state_nxt = S_REL_DB;
          w_cnt_nxt   = '0;
        end
      end

      // A release bounce returns to wherever the press was; hold stays frozen meanwhile.
      S_REL_DB: begin
        if (w_key_s) begin
          w_state_nxt = r_long_flag ? S_LONG : S_PRESSED;
        end else if (r_cnt == LP_DB_END) begin
          w_state_nxt     = S_IDLE;
          w_cnt_nxt       = '0;
          w_long_flag_nxt = 1'b0;
          w_release_nxt   = 1'b1;
          w_short_nxt     = ~r_long_flag;
        end else begin
          w_cnt_nxt = r_cnt + 26'd1;
        end
      end

      // Unused encodings fall back to idle with every pulse low.
      default: begin
        w_state_nxt     = S_IDLE;
        w_cnt_nxt       = '0;
        w_hold_nxt      = '0;
        w_long_flag_nxt = 1'b0;
      end
    endcase

    w_level_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_LONG) ||
                  (w_state_nxt == S_REL_DB);
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int TD = 4;
  localparam int TL = 20;

  logic I_clk;
  logic I_reset_n;
  logic I_key_n;
  logic O_key_level;
  logic O_press_pulse;
  logic O_release_pulse;
  logic O_short_press;
  logic O_long_press;

  int n_checks;
  int n_err;

  key_debounce #(.T_DEBOUNCE(TD), .T_LONG(TL)) dut (
    .I_clk          (I_clk),
    .I_reset_n      (I_reset_n),
    .I_key_n        (I_key_n),
    .O_key_level    (O_key_level),
    .O_press_pulse  (O_press_pulse),
    .O_release_pulse(O_release_pulse),
    .O_short_press  (O_short_press),
    .O_long_press   (O_long_press)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  // Reference model: tracks the debounced level, the length of the current run of
  // samples disagreeing with it, and the number of pressed samples counted so far.
  int   m_s1, m_s2;
  int   m_run, m_h;
  bit   m_lvl, m_longdone;
  bit   m_p, m_r, m_s, m_l;

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_run = 0; m_h = 0;
    m_lvl = 0; m_longdone = 0;
    m_p = 0; m_r = 0; m_s = 0; m_l = 0;
  endtask

  task automatic model_step();
    bit ks;
    ks = (m_s2 == 0);
    m_s2 = m_s1;
    m_s1 = int'(I_key_n);
    m_p = 0; m_r = 0; m_s = 0; m_l = 0;
    if (!m_lvl) begin
      if (ks) begin
        m_run++;
        if (m_run == TD + 1) begin
          m_lvl = 1; m_p = 1; m_h = 0; m_run = 0; m_longdone = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (!ks) begin
        m_run++;
        if (m_run == TD + 1) begin
          m_lvl = 0; m_r = 1; m_s = !m_longdone; m_run = 0;
        end
      end else begin
        if (m_run == 0 && !m_longdone) begin
          m_h++;
          if (m_h == TL) begin
            m_l = 1; m_longdone = 1;
          end
        end
        m_run = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge I_clk or negedge I_reset_n);
      if (!I_reset_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model plus pulse counters for directed tests.
  bit chk_en;
  int c_press, c_rel, c_short, c_long;

  initial begin
    chk_en = 0;
    c_press = 0; c_rel = 0; c_short = 0; c_long = 0;
    forever begin
      @(negedge I_clk);
      c_press += int'(O_press_pulse);
      c_rel   += int'(O_release_pulse);
      c_short += int'(O_short_press);
      c_long  += int'(O_long_press);
      if (chk_en)
        check("model_outputs",
              int'({O_key_level, O_press_pulse, O_release_pulse, O_short_press, O_long_press}),
              int'({m_lvl, m_p, m_r, m_s, m_l}));
    end
  end

  function automatic logic out_sel(input int w);
    case (w)
      0: return O_press_pulse;
      1: return O_release_pulse;
      2: return O_short_press;
      default: return O_long_press;
    endcase
  endfunction

  // Returns negedges waited until the selected output is high, or -1 on timeout.
  task automatic wait_out(input int which, input int bound, output int edges);
    edges = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge I_clk);
      if (out_sel(which)) begin
        edges = k + 1;
        break;
      end
    end
  endtask

  task automatic clear_counts();
    c_press = 0; c_rel = 0; c_short = 0; c_long = 0;
  endtask

  task automatic idle_key(input int n);
    I_key_n = 1'b1;
    repeat (n) @(negedge I_clk);
  endtask

  typedef struct {
    int low_n;
    int e_press;
    int e_rel;
    int e_short;
    int e_long;
  } vec_t;

  vec_t vecs[7];
  int   e;

  initial begin
    n_checks = 0;
    n_err = 0;
    I_key_n = 1'b1;
    I_reset_n = 1'b0;

    vecs[0] = '{3,  0, 0, 0, 0};
    vecs[1] = '{4,  0, 0, 0, 0};
    vecs[2] = '{5,  1, 1, 1, 0};
    vecs[3] = '{15, 1, 1, 1, 0};
    vecs[4] = '{24, 1, 1, 1, 0};
    vecs[5] = '{25, 1, 1, 0, 1};
    vecs[6] = '{40, 1, 1, 0, 1};

    // Reset state, key pressed so reset must hold everything low.
    I_key_n = 1'b0;
    repeat (3) @(negedge I_clk);
    check("reset_outputs",
          int'({O_key_level, O_press_pulse, O_release_pulse, O_short_press, O_long_press}), 0);
    I_key_n = 1'b1;
    #2 I_reset_n = 1'b1;
    chk_en = 1;
    idle_key(5);
    check("post_reset_level", int'(O_key_level), 0);

    // Table: press of a given length, then released long enough to settle.
    foreach (vecs[i]) begin
      idle_key(15);
      clear_counts();
      I_key_n = 1'b0;
      repeat (vecs[i].low_n) @(negedge I_clk);
      I_key_n = 1'b1;
      repeat (40) @(negedge I_clk);
      check($sformatf("vec%0d_press", i),   c_press, vecs[i].e_press);
      check($sformatf("vec%0d_release", i), c_rel,   vecs[i].e_rel);
      check($sformatf("vec%0d_short", i),   c_short, vecs[i].e_short);
      check($sformatf("vec%0d_long", i),    c_long,  vecs[i].e_long);
      check($sformatf("vec%0d_level", i),   int'(O_key_level), 0);
    end

    // Short press: press latency, level, release latency, short pulse.
    idle_key(15);
    clear_counts();
    I_key_n = 1'b0;
    wait_out(0, 30, e);
    check("short_press_latency", e, 7);
    check("short_level_with_press", int'(O_key_level), 1);
    repeat (10) @(negedge I_clk);
    I_key_n = 1'b1;
    wait_out(1, 30, e);
    check("short_release_latency", e, 7);
    check("short_pulse_with_release", int'(O_short_press), 1);
    check("short_level_falls", int'(O_key_level), 0);
    check("short_no_long", c_long, 0);

    // Long press: long pulse exactly TL edges after press, no short on release.
    idle_key(15);
    clear_counts();
    I_key_n = 1'b0;
    wait_out(0, 30, e);
    check("long_press_latency", e, 7);
    wait_out(3, 60, e);
    check("long_pulse_delay", e, 20);
    repeat (10) @(negedge I_clk);
    I_key_n = 1'b1;
    wait_out(1, 30, e);
    check("long_release_latency", e, 7);
    check("long_no_short", c_short, 0);
    check("long_once", c_long, 1);

    // Release bounce in PRESSED: hold freezes, long pulse delayed by 4 edges.
    idle_key(15);
    clear_counts();
    I_key_n = 1'b0;
    wait_out(0, 30, e);
    repeat (5) @(negedge I_clk);
    I_key_n = 1'b1;
    repeat (3) @(negedge I_clk);
    I_key_n = 1'b0;
    wait_out(3, 60, e);
    check("bounce_long_delay", e, 24 - 8);
    check("bounce_no_release", c_rel, 0);
    I_key_n = 1'b1;
    wait_out(1, 30, e);
    check("bounce_no_short", c_short, 0);

    // Reset while in S_LONG with key held, then fresh debounce.
    idle_key(15);
    clear_counts();
    I_key_n = 1'b0;
    wait_out(3, 60, e);
    check("rst_reach_long", e, 27);
    @(negedge I_clk);
    #2 I_reset_n = 1'b0;
    #1 check("rst_async_clear",
             int'({O_key_level, O_press_pulse, O_release_pulse, O_short_press, O_long_press}), 0);
    repeat (3) @(negedge I_clk);
    #2 I_reset_n = 1'b1;
    check("rst_no_pulses", c_rel + c_short, 0);
    wait_out(0, 30, e);
    check("rst_repress_latency", e, 7);
    I_key_n = 1'b1;
    idle_key(15);

    // Randomized runs of pressed/released with occasional resets.
    for (int r = 0; r < 300; r++) begin
      int len;
      if ($urandom_range(0, 9) == 0) len = $urandom_range(18, 35);
      else len = $urandom_range(1, 9);
      I_key_n = ~I_key_n;
      repeat (len) @(negedge I_clk);
      if ($urandom_range(0, 59) == 0) begin
        #2 I_reset_n = 1'b0;
        repeat (2) @(negedge I_clk);
        #2 I_reset_n = 1'b1;
      end
    end
    idle_key(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
